// File: rtl/axis_divide_seq.sv
// AXI-Stream radix-2 restoring divider, one quotient bit per clock.
// Joins a dividend and a divisor beat; emits {remainder, quotient}.
module axis_divide_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int SIGNED     = 1,
  parameter int TID_WIDTH  = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   a_tdata,
  input  logic                    a_tvalid,
  output logic                    a_tready,
  input  logic [TID_WIDTH-1:0]    a_tid,
  input  logic [DATA_WIDTH-1:0]   b_tdata,
  input  logic                    b_tvalid,
  output logic                    b_tready,
  output logic [2*DATA_WIDTH-1:0] result_tdata,
  output logic [1:0]              result_tuser,
  output logic [TID_WIDTH-1:0]    result_tid,
  output logic                    result_tlast,
  output logic                    result_tvalid,
  input  logic                    result_tready
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam bit SGN = (SIGNED != 0);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic [W-1:0]         q;
  logic [W-1:0]         rem;
  logic [W-1:0]         dvs;
  logic [W-1:0]         a_raw;
  logic                 sign_a;
  logic                 sign_b;
  logic                 dz;
  logic                 ovf;
  logic [TID_WIDTH-1:0] tid;

  logic         accept;
  logic         hs;
  logic         neg_a;
  logic         neg_b;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;
  logic         is_min;
  logic [W:0]   trial;
  logic         ge;
  logic [W-1:0] diff;
  logic [W-1:0] q_fix;
  logic [W-1:0] r_fix;

  assign accept = aresetn & (state == IDLE)
                & a_tvalid & b_tvalid;
  assign a_tready = accept;
  assign b_tready = accept;
  assign hs = result_tvalid & result_tready;
  assign result_tlast = result_tvalid;

  assign neg_a  = SGN & a_tdata[W-1];
  assign neg_b  = SGN & b_tdata[W-1];
  assign mag_a  = neg_a ? -a_tdata : a_tdata;
  assign mag_b  = neg_b ? -b_tdata : b_tdata;
  assign is_min = (a_tdata == {1'b1, {(W-1){1'b0}}});

  // Trial is W+1 bits; when it fits, the difference is below the divisor
  assign trial = {rem, q[W-1]};
  assign ge    = (trial >= {1'b0, dvs});
  assign diff  = trial[W-1:0] - dvs;

  always_comb begin
    q_fix = (sign_a ^ sign_b) ? -q : q;
    r_fix = sign_a ? -rem : rem;
    if (dz) begin
      q_fix = '1;
      r_fix = a_raw;
    end else if (ovf) begin
      q_fix = {1'b1, {(W-1){1'b0}}};
      r_fix = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt           <= '0;
      q             <= '0;
      rem           <= '0;
      dvs           <= '0;
      a_raw         <= '0;
      sign_a        <= 1'b0;
      sign_b        <= 1'b0;
      dz            <= 1'b0;
      ovf           <= 1'b0;
      tid           <= '0;
      result_tdata  <= '0;
      result_tuser  <= '0;
      result_tid    <= '0;
      result_tvalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            q      <= mag_a;
            dvs    <= mag_b;
            rem    <= '0;
            a_raw  <= a_tdata;
            sign_a <= neg_a;
            sign_b <= neg_b;
            dz     <= ~|b_tdata;
            ovf    <= SGN & is_min & (&b_tdata);
            tid    <= a_tid;
            cnt    <= CW'(W-1);
          end
        end
        CALC: begin
          rem <= ge ? diff : trial[W-1:0];
          q   <= {q[W-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          result_tdata <= {r_fix, q_fix};
          result_tuser <= {ovf, dz};
          result_tid   <= tid;
        end
        DONE: begin
          // Valid rises one cycle into DONE, drops on the handshake
          result_tvalid <= ~hs;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_divide_seq.sv
// Bench for axis_divide_seq: one signed and one unsigned 8-bit instance
// behind a shared stimulus port selected by sel.
module tb_axis_divide_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] a_tdata = '0;
  logic [7:0] b_tdata = '0;
  logic [3:0] a_tid = '0;
  logic       a_tvalid = 1'b0;
  logic       b_tvalid = 1'b0;
  logic       result_tready = 1'b0;

  logic        u_ar, u_br, u_tl, u_tv;
  logic        s_ar, s_br, s_tl, s_tv;
  logic [15:0] u_td, s_td;
  logic [1:0]  u_tu, s_tu;
  logic [3:0]  u_ti, s_ti;

  logic        a_rdy, b_rdy, r_tvalid, r_tlast;
  logic [15:0] r_tdata;
  logic [1:0]  r_tuser;
  logic [3:0]  r_tid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axis_divide_seq #(
    .DATA_WIDTH(8), .SIGNED(0), .TID_WIDTH(4)
  ) u_dut (
    .aclk(clk), .aresetn(rst_n),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid & ~sel),
    .a_tready(u_ar), .a_tid(a_tid),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid & ~sel),
    .b_tready(u_br),
    .result_tdata(u_td), .result_tuser(u_tu),
    .result_tid(u_ti), .result_tlast(u_tl),
    .result_tvalid(u_tv), .result_tready(result_tready)
  );

  axis_divide_seq #(
    .DATA_WIDTH(8), .SIGNED(1), .TID_WIDTH(4)
  ) s_dut (
    .aclk(clk), .aresetn(rst_n),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid & sel),
    .a_tready(s_ar), .a_tid(a_tid),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid & sel),
    .b_tready(s_br),
    .result_tdata(s_td), .result_tuser(s_tu),
    .result_tid(s_ti), .result_tlast(s_tl),
    .result_tvalid(s_tv), .result_tready(result_tready)
  );

  assign a_rdy    = sel ? s_ar : u_ar;
  assign b_rdy    = sel ? s_br : u_br;
  assign r_tvalid = sel ? s_tv : u_tv;
  assign r_tlast  = sel ? s_tl : u_tl;
  assign r_tdata  = sel ? s_td : u_td;
  assign r_tuser  = sel ? s_tu : u_tu;
  assign r_tid    = sel ? s_ti : u_ti;

  typedef struct {
    logic       sgn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic [1:0] user;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] ref_div(
    input logic sgn, input logic [7:0] a, input logic [7:0] b);
    logic [31:0] qq, rr;
    int sa, sb;
    if (b == 8'h00) return {2'b01, a, 8'hFF};
    if (sgn && a == 8'h80 && b == 8'hFF)
      return {2'b10, 8'h00, 8'h80};
    if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
    end else begin
      qq = {24'b0, a} / {24'b0, b};
      rr = {24'b0, a} % {24'b0, b};
    end
    return {2'b00, rr[7:0], qq[7:0]};
  endfunction

  task automatic issue(input logic sgn, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] tid);
    bit ok;
    ok = 0;
    sel = sgn;
    a_tdata = a;
    b_tdata = b;
    a_tid = tid;
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_rdy) begin
        ok = 1;
        break;
      end
    end
    if (ok) @(posedge clk);
    #1;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    chk("accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (r_tvalid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic sgn, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] tid,
                        output logic [15:0] data,
                        output logic [1:0] user,
                        output logic [3:0] tido,
                        output int lat);
    issue(sgn, a, b, tid);
    wait_res(lat);
    data = r_tdata;
    user = r_tuser;
    tido = r_tid;
    chk("tlast", {31'b0, r_tlast}, {31'b0, r_tvalid});
    @(posedge clk);
    #1;
    chk("tvalid_drop", {31'b0, r_tvalid}, 32'd0);
  endtask

  initial begin
    logic [15:0] d, hold_d;
    logic [1:0]  u, hold_u;
    logic [3:0]  t, hold_t;
    logic [17:0] e;
    logic [7:0]  ra, rb;
    logic        rs;
    int          lat;

    vt[0]  = '{1'b0, 8'hC8, 8'h07, 8'h1C, 8'h04, 2'b00};
    vt[1]  = '{1'b1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 2'b00};
    vt[2]  = '{1'b1, 8'h64, 8'hF9, 8'hF2, 8'h02, 2'b00};
    vt[3]  = '{1'b0, 8'h37, 8'h00, 8'hFF, 8'h37, 2'b01};
    vt[4]  = '{1'b1, 8'h37, 8'h00, 8'hFF, 8'h37, 2'b01};
    vt[5]  = '{1'b1, 8'hF0, 8'h00, 8'hFF, 8'hF0, 2'b01};
    vt[6]  = '{1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 2'b10};
    vt[7]  = '{1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 2'b00};
    vt[8]  = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h00, 2'b00};
    vt[9]  = '{1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 2'b00};
    vt[10] = '{1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 2'b00};
    vt[11] = '{1'b1, 8'h7F, 8'h80, 8'h00, 8'h7F, 2'b00};
    vt[12] = '{1'b0, 8'h09, 8'h03, 8'h03, 8'h00, 2'b00};
    vt[13] = '{1'b1, 8'h80, 8'h02, 8'hC0, 8'h00, 2'b00};
    vt[14] = '{1'b1, 8'h85, 8'hF6, 8'h0C, 8'hFD, 2'b00};

    // Reset state, with both valids high
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #3;
      chk("rst_tvalid", {31'b0, r_tvalid}, 32'd0);
      chk("rst_tdata", {16'b0, r_tdata}, 32'd0);
      chk("rst_tuser", {30'b0, r_tuser}, 32'd0);
      chk("rst_tid", {28'b0, r_tid}, 32'd0);
      chk("rst_a_tready", {31'b0, a_rdy}, 32'd0);
      chk("rst_b_tready", {31'b0, b_rdy}, 32'd0);
    end
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    result_tready = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].sgn, vt[i].a, vt[i].b, 4'(i), d, u, t, lat);
      chk($sformatf("v%0d_q", i), {24'b0, d[7:0]}, {24'b0, vt[i].q});
      chk($sformatf("v%0d_r", i), {24'b0, d[15:8]}, {24'b0, vt[i].r});
      chk($sformatf("v%0d_user", i), {30'b0, u}, {30'b0, vt[i].user});
      chk($sformatf("v%0d_tid", i), {28'b0, t}, 32'(i));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd10);
    end

    // Back-pressure with a new operation already waiting
    result_tready = 1'b0;
    issue(1'b1, 8'h9C, 8'h07, 4'd5);
    wait_res(lat);
    chk("bp_lat", 32'(lat), 32'd10);
    hold_d = r_tdata;
    hold_u = r_tuser;
    hold_t = r_tid;
    chk("bp_data", {16'b0, hold_d}, 32'h0000FEF2);
    chk("bp_tid", {28'b0, hold_t}, 32'd5);
    a_tdata = 8'd50;
    b_tdata = 8'd5;
    a_tid = 4'd6;
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data", {16'b0, r_tdata}, {16'b0, hold_d});
      chk("bp_hold_user", {30'b0, r_tuser}, {30'b0, hold_u});
      chk("bp_hold_tid", {28'b0, r_tid}, {28'b0, hold_t});
      chk("bp_hold_valid", {31'b0, r_tvalid}, 32'd1);
      chk("bp_a_tready", {31'b0, a_rdy}, 32'd0);
      chk("bp_b_tready", {31'b0, b_rdy}, 32'd0);
    end
    @(negedge clk);
    result_tready = 1'b1;
    #1;
    chk("bp_hs_a_tready", {31'b0, a_rdy}, 32'd0);
    @(posedge clk);
    #1;
    chk("bp_after_valid", {31'b0, r_tvalid}, 32'd0);
    chk("bp_next_ready", {31'b0, a_rdy & b_rdy}, 32'd1);
    @(posedge clk);
    #1;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    wait_res(lat);
    chk("bp2_lat", 32'(lat), 32'd10);
    chk("bp2_data", {16'b0, r_tdata}, 32'h0000000A);
    chk("bp2_tid", {28'b0, r_tid}, 32'd6);
    @(posedge clk);
    #1;

    // Lone dividend valid is held, not consumed
    sel = 1'b0;
    a_tdata = 8'd20;
    b_tdata = 8'd6;
    a_tid = 4'd7;
    a_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lone_a_tready", {31'b0, a_rdy}, 32'd0);
      chk("lone_b_tready", {31'b0, b_rdy}, 32'd0);
    end
    b_tvalid = 1'b1;
    #1;
    chk("join_a_tready", {31'b0, a_rdy}, 32'd1);
    chk("join_b_tready", {31'b0, b_rdy}, 32'd1);
    @(posedge clk);
    #1;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    wait_res(lat);
    chk("join_lat", 32'(lat), 32'd10);
    chk("join_data", {16'b0, r_tdata}, 32'h00000203);
    chk("join_tid", {28'b0, r_tid}, 32'd7);
    @(posedge clk);
    #1;

    // Reset in the middle of CALC
    issue(1'b0, 8'd100, 8'd7, 4'd2);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    a_tdata = 8'd9;
    b_tdata = 8'd3;
    a_tid = 4'd9;
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, r_tvalid}, 32'd0);
    chk("mid_rst_ready", {31'b0, a_rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, a_rdy}, 32'd1);
    @(posedge clk);
    #1;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    wait_res(lat);
    chk("post_rst_lat", 32'(lat), 32'd10);
    chk("post_rst_data", {16'b0, r_tdata}, 32'h00000003);
    chk("post_rst_tid", {28'b0, r_tid}, 32'd9);
    @(posedge clk);
    #1;

    // Random operands against the reference model
    for (int i = 0; i < 1000; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        ra = 8'h80;
        rb = 8'hFF;
      end
      e = ref_div(rs, ra, rb);
      run_op(rs, ra, rb, 4'(i), d, u, t, lat);
      chk($sformatf("rnd%0d s%0d %0h/%0h", i, rs, ra, rb),
          {14'b0, u, d}, {14'b0, e});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
